// File: rtl/rc4_pkg.sv
// rc4_pkg: shared sizes and FSM state encoding for the RC4 key-scheduling controller.
package rc4_pkg;
    localparam int N = 16;
    localparam int W = 4;
    typedef enum logic [2:0] {IDLE, INIT, LOAD, SWAP, WRITE, DONE} state_e;
endpackage

// File: rtl/rc4_state_mem.sv
// rc4_state_mem: 16 x 4-bit RC4 state array S.
// Ports: clk/reset (async active-low, clears S); we writes wd1 to wa1, and with we2
// also wd2 to wa2 (skipped when wa2 == wa1); ra1/ra2/ra3 are combinational reads.
module rc4_state_mem
    import rc4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic         we2,
    input  logic [W-1:0] wa1,
    input  logic [W-1:0] wd1,
    input  logic [W-1:0] wa2,
    input  logic [W-1:0] wd2,
    input  logic [W-1:0] ra1,
    input  logic [W-1:0] ra2,
    input  logic [W-1:0] ra3,
    output logic [W-1:0] rd1,
    output logic [W-1:0] rd2,
    output logic [W-1:0] rd3
);
    logic [W-1:0] mem_q [N];
    logic [W-1:0] mem_d [N];

    // A self-swap (wa1 == wa2) collapses to one write; both data carry the same value.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[wa1] = wd1;
        if (we && we2 && wa2 != wa1) mem_d[wa2] = wd2;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) mem_q <= '{default: '0};
        else        mem_q <= mem_d;

    assign rd1 = mem_q[ra1];
    assign rd2 = mem_q[ra2];
    assign rd3 = mem_q[ra3];
endmodule

// File: rtl/rc4_ksa_ctrl.sv
// rc4_ksa_ctrl: RC4 key-scheduling controller driving an external Swap stage.
// Ports: clk, reset (async active-low); start/key/key_len launch a run (key_len 0 = 16);
// sw_in1/sw_in2/sw_sel feed the Swap stage, sw_out1/sw_out2 return its registers;
// busy spans INIT..WRITE, done pulses once; rd_addr/rd_data read S combinationally.
module rc4_ksa_ctrl
    import rc4_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N*W-1:0]  key,
    input  logic [W-1:0]    key_len,
    output logic [W-1:0]    sw_in1,
    output logic [W-1:0]    sw_in2,
    output logic            sw_sel,
    input  logic [W-1:0]    sw_out1,
    input  logic [W-1:0]    sw_out2,
    output logic            busy,
    output logic            done,
    input  logic [W-1:0]    rd_addr,
    output logic [W-1:0]    rd_data
);
    state_e           state_q, state_d;
    logic [W-1:0]     i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [N*W-1:0]   key_q, key_d;
    logic             we, we2;
    logic [W-1:0]     wd1, s_i, s_jn, jn, key_nib;

    rc4_state_mem u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .we2   (we2),
        .wa1   (i_q),
        .wd1   (wd1),
        .wa2   (j_q),
        .wd2   (sw_out2),
        .ra1   (i_q),
        .ra2   (jn),
        .ra3   (rd_addr),
        .rd1   (s_i),
        .rd2   (s_jn),
        .rd3   (rd_data)
    );

    assign key_nib = key_q[{k_q, 2'b00} +: W];
    assign jn      = j_q + s_i + key_nib;

    // INIT writes i to S[i]; WRITE takes the swapped pair back from the Swap stage.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        key_d   = key_q;
        len_d   = len_q;
        we      = 1'b0;
        we2     = 1'b0;
        wd1     = i_q;
        sw_in1  = '0;
        sw_in2  = '0;
        case (state_q)
            IDLE: if (start) begin
                state_d = INIT;
                i_d     = '0;
                key_d   = key;
                len_d   = key_len;
            end
            INIT: begin
                we      = 1'b1;
                i_d     = i_q + 1'b1;
                j_d     = '0;
                k_d     = '0;
                state_d = i_q == W'(N - 1) ? LOAD : INIT;
            end
            LOAD: begin
                j_d     = jn;
                sw_in1  = s_i;
                sw_in2  = s_jn;
                state_d = SWAP;
            end
            SWAP: state_d = WRITE;
            WRITE: begin
                we      = 1'b1;
                we2     = 1'b1;
                wd1     = sw_out1;
                i_d     = i_q + 1'b1;
                // len_q - 1 wraps to 15 when key_len is 0, giving a 16-nibble key.
                k_d     = k_q == len_q - 1'b1 ? '0 : k_q + 1'b1;
                state_d = i_q == W'(N - 1) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            key_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            key_q   <= key_d;
            len_q   <= len_d;
        end

    assign busy   = state_q inside {INIT, LOAD, SWAP, WRITE};
    assign done   = state_q == DONE;
    assign sw_sel = state_q == SWAP;
endmodule

// File: tb/tb_rc4_ksa_ctrl.sv
// tb_rc4_ksa_ctrl: directed self-checking bench with an external Swap stage model.
module tb_rc4_ksa_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic [3:0]  key_len = 4'd1;
    logic [3:0]  sw_in1, sw_in2, sw_out1, sw_out2;
    logic        sw_sel, busy, done;
    logic [3:0]  rd_addr = '0;
    logic [3:0]  rd_data;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    rc4_ksa_ctrl dut (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start),
        .key     (key),
        .key_len (key_len),
        .sw_in1  (sw_in1),
        .sw_in2  (sw_in2),
        .sw_sel  (sw_sel),
        .sw_out1 (sw_out1),
        .sw_out2 (sw_out2),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Swap stage: sel=0 loads the operands, sel=1 exchanges the two registers.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sw_out1 <= '0;
            sw_out2 <= '0;
        end else if (sw_sel) begin
            sw_out1 <= sw_out2;
            sw_out2 <= sw_out1;
        end else begin
            sw_out1 <= sw_in1;
            sw_out2 <= sw_in2;
        end

    function automatic logic [63:0] ksa_model(input logic [63:0] k, input logic [3:0] len);
        logic [3:0] s [16];
        logic [3:0] t;
        int j = 0;
        int l = (len == 0) ? 16 : int'(len);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) s[n] = 4'(n);
        for (int n = 0; n < 16; n++) begin
            j = (j + int'(s[n]) + int'(k[4*(n%l) +: 4])) % 16;
            t = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 16; n++) r[4*n +: 4] = s[n];
        return r;
    endfunction

    task automatic read_s(output logic [63:0] r);
        for (int n = 0; n < 16; n++) begin
            rd_addr = 4'(n);
            #1 r[4*n +: 4] = rd_data;
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (start sampled at edge 0).
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until done is seen; optionally pulses start again in cycle poke.
    task automatic run_to_done(input int poke, output int done_cyc);
        done_cyc = -1;
        start_pulse();
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            if (done) done_cyc = c;
            else begin
                start = (c == poke);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] k, input logic [3:0] len, input int poke);
        int dc;
        logic [63:0] s, exp;
        logic [15:0] seen;
        key = k;
        key_len = len;
        run_to_done(poke, dc);
        total++;
        if (dc != 65) $display("FAIL %s done cycle: got %0d want 65", name, dc);
        else passed++;
        read_s(s);
        exp = ksa_model(k, len);
        total++;
        if (s !== exp) $display("FAIL %s final S: got %h want %h", name, s, exp);
        else passed++;
        seen = '0;
        for (int n = 0; n < 16; n++) seen[s[4*n +: 4]] = 1'b1;
        total++;
        if (seen !== 16'hFFFF) $display("FAIL %s permutation: got %h want ffff", name, seen);
        else passed++;
    endtask

    task automatic test_reset();
        logic [63:0] s;
        #1;
        total++;
        if ({busy, done, sw_sel, sw_in1, sw_in2} !== 11'b0)
            $display("FAIL reset outputs: got %b want 0", {busy, done, sw_sel, sw_in1, sw_in2});
        else passed++;
        read_s(s);
        total++;
        if (s !== 64'h0) $display("FAIL reset S: got %h want 0", s);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL idle without start: busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        int bad_busy = 0, bad_done = 0, bad_sel = 0;
        key = '0;
        key_len = 4'd1;
        start_pulse();
        for (int c = 1; c <= 66; c++) begin
            if (busy !== (c <= 64)) bad_busy++;
            if (done !== (c == 65)) bad_done++;
            if (sw_sel !== (c >= 18 && c <= 63 && c % 3 == 0)) bad_sel++;
            if (c == 26) begin
                rd_addr = 4'd2;
                #1 total++;
                if (rd_data !== 4'd3) $display("FAIL mid-run S[2]: got %0d want 3", rd_data);
                else passed++;
                rd_addr = 4'd3;
                #1 total++;
                if (rd_data !== 4'd2) $display("FAIL mid-run S[3]: got %0d want 2", rd_data);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (bad_busy != 0) $display("FAIL busy window: got %0d bad cycles want 0", bad_busy);
        else passed++;
        total++;
        if (bad_done != 0) $display("FAIL done pulse: got %0d bad cycles want 0", bad_done);
        else passed++;
        total++;
        if (bad_sel != 0) $display("FAIL sw_sel pattern: got %0d bad cycles want 0", bad_sel);
        else passed++;
    endtask

    // key nibble 8, len 1: step 0 swaps S[0]/S[8], step 1 lands on j == i == 1.
    task automatic test_i_eq_j();
        logic [63:0] s;
        key = 64'h8;
        key_len = 4'd1;
        start_pulse();
        repeat (22) @(negedge clk);
        read_s(s);
        total++;
        if (s[15:0] !== 16'h3218 || s[35:32] !== 4'h0)
            $display("FAIL i==j step: got S[3:0]=%h S[8]=%h want 3218/0", s[15:0], s[35:32]);
        else passed++;
        repeat (60) @(negedge clk);
        read_s(s);
        total++;
        if (s !== ksa_model(64'h8, 4'd1)) $display("FAIL i==j final S: got %h want %h", s, ksa_model(64'h8, 4'd1));
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] s;
        int seen_done = 0;
        key = 64'h0123456789abcdef;
        key_len = 4'd0;
        start_pulse();
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1 total++;
        if ({busy, done, sw_sel} !== 3'b0) $display("FAIL async abort: got %b want 000", {busy, done, sw_sel});
        else passed++;
        read_s(s);
        total++;
        if (s !== 64'h0) $display("FAIL abort S cleared: got %h want 0", s);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        total++;
        if (seen_done != 0) $display("FAIL activity after abort: got %0d cycles want 0", seen_done);
        else passed++;
    endtask

    logic [63:0] rkey;

    initial begin
        rkey = {$urandom, $urandom};
        test_reset();
        test_basic();
        check_result("golden len16", rkey, 4'd0, 0);
        check_result("golden len5", rkey, 4'd5, 0);
        check_result("start while busy", rkey, 4'd5, 30);
        test_i_eq_j();
        test_reset_mid();
        check_result("fresh after abort", 64'hfedcba9876543210, 4'd7, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
